gnrl_vr_fifo: RTL



---
 rtl/gnrl_vr_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/gnrl_vr_fifo.sv
// Synchronous valid/ready FIFO with registered handshake outputs and an
// explicit occupancy counter that decides full/empty.
module gnrl_vr_fifo #(
  parameter int DW = 32,
  parameter int DP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake: a word moves on a rising edge only when valid and ready are
  // both 1 on that side; ready/valid here depend on registered state only.
  input  logic                  i_vld,
  output logic                  i_rdy,
  input  logic [DW-1:0]         i_dat,
  output logic                  o_vld,
  input  logic                  o_rdy,
  output logic [DW-1:0]         o_dat,
  output logic [$clog2(DP):0]   cnt
);

  localparam int AW = $clog2(DP);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [DW-1:0] mem_q [DP];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Occupancy alone separates full from empty, since the pointers are equal in both.
  assign full  = (cnt_q == CW'(DP));
  assign empty = (cnt_q == '0);
  assign push  = i_vld && !full;
  assign pop   = o_rdy && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage holds no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wptr_q] <= i_dat;
    end
  end

  assign i_rdy = !full;
  assign o_vld = !empty;
  assign o_dat = mem_q[rptr_q];
  assign cnt   = cnt_q;

endmodule
